// File: rtl/dmemu_wr_pkg.sv
// Shared encodings for the store-side data memory unit: store widths,
// strobe width, FSM states and the timeout counter sizing rule.
package dmemu_wr_pkg;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    localparam int STRB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A zero timeout still needs a one-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/dmemu_wr_align.sv
// Store lane alignment: turns width, byte offset and rs2 into write strobes,
// replicated lane data and the alignment/legality flags.
module dmemu_wr_align
    import dmemu_wr_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [31:0]       data,
    output logic [STRB_W-1:0] strb,
    output logic [31:0]       lane_data,
    output logic              misalign,
    output logic              legal
);

    always_comb begin
        strb      = '0;
        lane_data = '0;
        misalign  = 1'b0;
        legal     = 1'b0;
        case (funct3)
            FUNCT3_SB: begin
                legal     = 1'b1;
                strb      = 4'b0001 << off;
                lane_data = {4{data[7:0]}};
            end
            FUNCT3_SH: begin
                legal     = 1'b1;
                misalign  = off[0];
                strb      = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{data[15:0]}};
            end
            FUNCT3_SW: begin
                legal     = 1'b1;
                misalign  = |off;
                strb      = 4'b1111;
                lane_data = data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmemu_wr.sv
// MEM-stage store unit: registers an aligned store onto the dmem write port
// and holds it with a req/ack handshake, flagging misaligned stores and timeouts.
module dmemu_wr
    import dmemu_wr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_is_store,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_dmem_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_ready,
    output logic              o_stall,
    output logic              o_misalign,
    output logic [31:0]       o_misalign_addr,
    output logic              o_bus_err,
    output logic              o_dmem_wr_req,
    output logic [31:0]       o_dmem_wr_addr,
    output logic [31:0]       o_dmem_wr_data,
    output logic [STRB_W-1:0] o_dmem_wr_strb,
    input  logic              i_dmem_wr_ack
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [STRB_W-1:0]  al_strb;
    logic [31:0]        al_data;
    logic               al_misalign;
    logic               al_legal;
    logic               store;
    logic               acc;
    logic               mis_drop;
    logic               timeout;

    dmemu_wr_align u_align (
        .funct3    (i_funct3),
        .off       (i_dmem_addr[1:0]),
        .data      (i_store_data),
        .strb      (al_strb),
        .lane_data (al_data),
        .misalign  (al_misalign),
        .legal     (al_legal)
    );

    // An ack frees the port in the same cycle, which is what allows back-to-back stores.
    assign o_ready  = (state == IDLE) | i_dmem_wr_ack;
    assign o_stall  = i_valid & i_is_store & ~o_ready;
    assign store    = i_valid & i_is_store & al_legal;
    assign acc      = store & ~al_misalign & o_ready;
    assign mis_drop = store & al_misalign & o_ready;
    assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            o_dmem_wr_req   <= 1'b0;
            o_dmem_wr_addr  <= '0;
            o_dmem_wr_data  <= '0;
            o_dmem_wr_strb  <= '0;
            o_misalign      <= 1'b0;
            o_misalign_addr <= '0;
            o_bus_err       <= 1'b0;
        end else begin
            o_misalign <= mis_drop;
            o_bus_err  <= 1'b0;
            if (mis_drop) begin
                o_misalign_addr <= i_dmem_addr;
            end

            // acc in BUSY implies ack, so a new load also retires the current request.
            if (acc) begin
                state          <= BUSY;
                cnt            <= '0;
                o_dmem_wr_req  <= 1'b1;
                o_dmem_wr_addr <= {i_dmem_addr[31:2], 2'b00};
                o_dmem_wr_data <= al_data;
                o_dmem_wr_strb <= al_strb;
            end else if (state == BUSY) begin
                if (i_dmem_wr_ack) begin
                    state         <= IDLE;
                    o_dmem_wr_req <= 1'b0;
                end else if (timeout) begin
                    state         <= IDLE;
                    o_dmem_wr_req <= 1'b0;
                    o_bus_err     <= 1'b1;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmemu_wr.sv
// Scoreboard bench for dmemu_wr: directed scenarios plus randomized stores,
// expected writes derived from byte-range rules and checked by a monitor.
module tb_dmemu_wr;

    localparam int TMO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] sdata = '0;
    logic        ack = 1'b0;
    logic        ready;
    logic        stall;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        bus_err;
    logic        req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    int n_chk = 0;
    int n_pass = 0;
    wr_t         wr_q[$];
    logic [31:0] mis_q[$];
    int          exp_berr = 0;
    int          ack_delay = -1;
    int          wait_cnt = 0;

    dmemu_wr #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_valid         (valid),
        .i_is_store      (is_store),
        .i_funct3        (funct3),
        .i_dmem_addr     (addr),
        .i_store_data    (sdata),
        .o_ready         (ready),
        .o_stall         (stall),
        .o_misalign      (misalign),
        .o_misalign_addr (misalign_addr),
        .o_bus_err       (bus_err),
        .o_dmem_wr_req   (req),
        .o_dmem_wr_addr  (wr_addr),
        .o_dmem_wr_data  (wr_data),
        .o_dmem_wr_strb  (wr_strb),
        .i_dmem_wr_ack   (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: a store of 2^funct3 bytes covers byte addresses [a, a+size);
    // each lane carries the store byte that repeats with period size.
    function automatic void model_push(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] d);
        int  size;
        int  off;
        wr_t t;
        if (f3 > 3'd2) return;
        size = 1 << f3;
        off  = int'(a % 4);
        if ((a % size) != 0) begin
            mis_q.push_back(a);
            return;
        end
        t.addr = a - off;
        for (int n = 0; n < 4; n++) begin
            t.strb[n]       = (n >= off) && (n < off + size);
            t.data[8*n +: 8] = d[8*(n % size) +: 8];
        end
        wr_q.push_back(t);
    endfunction

    // Ack responder: random with a forced ack after two waits, fixed delay, or never.
    always @(negedge clk) begin
        if (req && !ack) wait_cnt++;
        else wait_cnt = 0;
    end

    always begin
        @(posedge clk);
        #1;
        if (ack_delay < 0) begin
            if (req) ack = (wait_cnt >= 2) ? 1'b1 : 1'($urandom % 2);
            else ack = ($urandom % 4) == 0;
        end else begin
            ack = req && (wait_cnt >= ack_delay);
        end
    end

    logic        hold = 1'b0;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_strb;

    always @(negedge clk) begin
        wr_t t;
        logic [31:0] ma;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold && req) begin
                chk("hold_addr", wr_addr, h_addr);
                chk("hold_data", wr_data, h_data);
                chk("hold_strb", 32'(wr_strb), 32'(h_strb));
            end
            if (req && ack) begin
                chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    t = wr_q.pop_front();
                    chk("wr_addr", wr_addr, t.addr);
                    chk("wr_data", wr_data, t.data);
                    chk("wr_strb", 32'(wr_strb), 32'(t.strb));
                end
            end
            if (misalign) begin
                chk("mis_expected", 32'(mis_q.size() != 0), 32'd1);
                if (mis_q.size() != 0) begin
                    ma = mis_q.pop_front();
                    chk("mis_addr", misalign_addr, ma);
                end
            end
            if (bus_err) begin
                chk("berr_expected", 32'(exp_berr > 0), 32'd1);
                if (exp_berr > 0) exp_berr--;
            end
            hold   = req && !ack;
            h_addr = wr_addr;
            h_data = wr_data;
            h_strb = wr_strb;
        end
    end

    // Called just after a posedge; returns just after a later posedge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit track, output int stalls);
        stalls   = 0;
        valid    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        sdata    = d;
        if (st) begin
            @(negedge clk);
            while (!ready && stalls < 100) begin
                chk("stall_busy", 32'(stall), 32'd1);
                stalls++;
                @(posedge clk);
                #1;
                @(negedge clk);
            end
            chk("ready_seen", 32'(ready), 32'd1);
            chk("stall_ready", 32'(stall), 32'd0);
            if (track) model_push(f3, a, d);
        end
        @(posedge clk);
        #1;
        valid    = 1'b0;
        is_store = 1'b0;
    endtask

    task automatic count_req(input int n, output int nreq, output int nberr);
        nreq  = 0;
        nberr = 0;
        repeat (n) begin
            @(negedge clk);
            nreq  += int'(req);
            nberr += int'(bus_err);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!req) break;
        end
        chk("idle_reached", 32'(req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, nr, nb;
        logic [2:0] f3;
        int r;

        #2;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", wr_addr, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_strb", 32'(wr_strb), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_mis_addr", misalign_addr, 32'd0);
        chk("rst_berr", 32'(bus_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // SB at offset 3, ack after two waits
        ack_delay = 2;
        issue(1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1, st);
        chk("t1_stall", 32'(st), 32'd0);
        @(negedge clk);
        chk("t1_req", 32'(req), 32'd1);
        chk("t1_addr", wr_addr, 32'h0000_1000);
        chk("t1_strb", 32'(wr_strb), 32'b1000);
        chk("t1_data", wr_data, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        count_req(5, nr, nb);
        chk("t1_req_rest", 32'(nr), 32'd2);

        ack_delay = -1;
        issue(1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 1, st);
        issue(1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 1, st);
        wait_idle();

        // Back-to-back words with a one-cycle ack delay
        ack_delay = 1;
        issue(1, 3'b010, 32'h0000_3000, 32'h1111_2222, 1, st);
        issue(1, 3'b010, 32'h0000_3004, 32'h3333_4444, 1, st);
        chk("t3_stall_cycles", 32'(st), 32'd1);
        @(negedge clk);
        chk("t3_req_kept", 32'(req), 32'd1);
        chk("t3_addr2", wr_addr, 32'h0000_3004);
        @(posedge clk);
        #1;
        wait_idle();

        // Misaligned stores
        ack_delay = -1;
        issue(1, 3'b010, 32'h0000_4002, 32'hCAFE_F00D, 1, st);
        @(negedge clk);
        chk("t4_no_req", 32'(req), 32'd0);
        chk("t4_mis", 32'(misalign), 32'd1);
        chk("t4_mis_addr", misalign_addr, 32'h0000_4002);
        @(posedge clk);
        #1;
        issue(1, 3'b001, 32'h0000_4001, 32'h0000_5A5A, 1, st);
        issue(1, 3'b000, 32'h0000_4001, 32'h0000_0077, 1, st);
        @(negedge clk);
        chk("t4_sb_strb", 32'(wr_strb), 32'b0010);
        @(posedge clk);
        #1;
        wait_idle();

        // Ack timeout
        ack_delay = 1000;
        exp_berr++;
        issue(1, 3'b010, 32'h0000_5000, 32'h0BAD_0BAD, 0, st);
        count_req(8, nr, nb);
        chk("t5_req_cycles", 32'(nr), 32'(TMO));
        chk("t5_berr_cycles", 32'(nb), 32'd1);
        ack_delay = -1;
        issue(1, 3'b010, 32'h0000_5004, 32'h600D_600D, 1, st);
        chk("t5_after_stall", 32'(st), 32'd0);
        wait_idle();

        // Reset while a request is outstanding
        ack_delay = 1000;
        issue(1, 3'b010, 32'h0000_6000, 32'hFFFF_0000, 0, st);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_drop", 32'(req), 32'd0);
        chk("t6_strb_drop", 32'(wr_strb), 32'd0);
        chk("t6_data_drop", wr_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready", 32'(ready), 32'd1);
        chk("t6_req_idle", 32'(req), 32'd0);
        @(posedge clk);
        #1;
        ack_delay = -1;

        // Randomized traffic, including non-stores and illegal widths
        for (int k = 0; k < 400; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            r  = $urandom_range(0, 9);
            f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            issue(($urandom % 10) != 0, f3, $urandom, $urandom, 1, st);
        end

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wr_q.size() == 0 && mis_q.size() == 0 && exp_berr == 0) break;
        end
        chk("drain_wr", 32'(wr_q.size()), 32'd0);
        chk("drain_mis", 32'(mis_q.size()), 32'd0);
        chk("drain_berr", 32'(exp_berr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
